// File: rtl/beep_note_sequencer.sv
// beep_note_sequencer: picks the half-period divider for the buzzer tone generator.
// Plays a fixed melody from an internal ROM, or a note requested by a PS/2 key.
// A key press preempts the melody; when the key note expires the melody resumes
// at the entry after the interrupted one.
//
// Ports
//   i_clk_50m    system clock
//   i_rst_n      synchronous active-low reset
//   i_play       1-cycle pulse: start the melody from entry 0 (ignored while busy)
//   i_stop       1-cycle pulse: abort everything and go silent
//   i_key_valid  1-cycle pulse: i_key_code holds a new make code
//   i_key_code   PS/2 scan code
//   o_freq_div   half-period count for the tone generator (0 = silent)
//   o_busy       high in any state except IDLE
//   o_done       1-cycle pulse at melody end (LOOP=0 only)
module beep_note_sequencer #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned BEAT_MS   = 250,
  parameter int unsigned GAP_MS    = 20,
  parameter int unsigned MANUAL_MS = 200,
  parameter int unsigned SONG_LEN  = 8,
  parameter int unsigned LOOP      = 0
) (
  input  logic        i_clk_50m,
  input  logic        i_rst_n,
  input  logic        i_play,
  input  logic        i_stop,
  input  logic        i_key_valid,
  input  logic [7:0]  i_key_code,
  output logic [15:0] o_freq_div,
  output logic        o_busy,
  output logic        o_done
);

  localparam int unsigned TICK_W = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
  localparam int unsigned MS_MAX = (BEAT_MS * 15) + GAP_MS + MANUAL_MS;
  localparam int unsigned MS_W   = $clog2(MS_MAX + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0]   BEAT_T    = MS_W'(BEAT_MS);
  localparam logic [MS_W-1:0]   GAP_T     = MS_W'(GAP_MS);
  localparam logic [MS_W-1:0]   MAN_T     = MS_W'(MANUAL_MS);
  localparam logic [4:0]        SONG_END  = 5'(SONG_LEN);
  localparam logic              LOOP_EN   = (LOOP != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_MANUAL
  } state_t;

  // Note index -> half-period divider.
  function automatic logic [15:0] note_div(input logic [3:0] idx);
    logic [15:0] d;
    case (idx)
      4'd1:    d = 16'd47774;
      4'd2:    d = 16'd42568;
      4'd3:    d = 16'd37919;
      4'd4:    d = 16'd35791;
      4'd5:    d = 16'd31888;
      4'd6:    d = 16'd28409;
      4'd7:    d = 16'd25309;
      4'd8:    d = 16'd23889;
      4'd9:    d = 16'd21276;
      default: d = 16'd0;
    endcase
    return d;
  endfunction

  // Scan code -> {hit, note index}; unmapped codes return hit=0.
  function automatic logic [4:0] key_map(input logic [7:0] code);
    logic [4:0] k;
    case (code)
      8'h70:   k = {1'b1, 4'd0};
      8'h69:   k = {1'b1, 4'd1};
      8'h72:   k = {1'b1, 4'd2};
      8'h7A:   k = {1'b1, 4'd3};
      8'h6B:   k = {1'b1, 4'd4};
      8'h73:   k = {1'b1, 4'd5};
      8'h74:   k = {1'b1, 4'd6};
      8'h6C:   k = {1'b1, 4'd7};
      8'h75:   k = {1'b1, 4'd8};
      8'h7D:   k = {1'b1, 4'd9};
      default: k = 5'd0;
    endcase
    return k;
  endfunction

  // Melody ROM, {note, dur}; anything past the table reads as an end marker.
  function automatic logic [7:0] rom_entry(input logic [3:0] idx);
    logic [7:0] e;
    case (idx)
      4'd0:    e = {4'd1, 4'd1};
      4'd1:    e = {4'd1, 4'd1};
      4'd2:    e = {4'd5, 4'd1};
      4'd3:    e = {4'd5, 4'd1};
      4'd4:    e = {4'd6, 4'd1};
      4'd5:    e = {4'd6, 4'd1};
      4'd6:    e = {4'd5, 4'd2};
      4'd7:    e = {4'd0, 4'd1};
      default: e = 8'h00;
    endcase
    return e;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_index;
  logic [3:0]        w_index_nxt;
  logic [3:0]        r_dur;
  logic [3:0]        w_dur_nxt;
  logic              r_paused;
  logic              w_paused_nxt;
  logic [15:0]       w_freq_nxt;
  logic              w_done_nxt;
  logic              w_restart;
  logic              w_clr;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [MS_W-1:0]   r_ms_cnt;
  logic              w_tick;
  logic [MS_W-1:0]   w_target;
  logic              w_expire;
  logic [4:0]        w_key;
  logic              w_key_hit;
  logic [3:0]        w_key_idx;
  logic [7:0]        w_rom;
  logic [3:0]        w_rom_note;
  logic [3:0]        w_rom_dur;
  logic              w_end;

  assign w_key      = key_map(i_key_code);
  assign w_key_hit  = w_key[4];
  assign w_key_idx  = w_key[3:0];
  assign w_rom      = rom_entry(r_index);
  assign w_rom_note = w_rom[7:4];
  assign w_rom_dur  = w_rom[3:0];
  assign w_end      = (w_rom_dur == 4'd0) || ({1'b0, r_index} >= SONG_END);

  // Timers restart on every state entry and on a MANUAL re-trigger.
  assign w_clr  = (w_state_nxt != r_state) || w_restart;
  assign w_tick = (r_tick_cnt == TICK_LAST);

  // Length of the current timed state in ms.
  always_comb begin
    w_target = '0;
    case (r_state)
      S_PLAY:   w_target = MS_W'(r_dur) * BEAT_T;
      S_GAP:    w_target = GAP_T;
      S_MANUAL: w_target = MAN_T;
      default:  w_target = '0;
    endcase
  end

  assign w_expire = w_tick && (r_ms_cnt == (w_target - MS_W'(1)));

  // ms tick prescaler and ms-in-state counter.
  always_ff @(posedge i_clk_50m) begin
    if (!i_rst_n || w_clr) begin
      r_tick_cnt <= '0;
      r_ms_cnt   <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
      r_ms_cnt   <= r_ms_cnt + MS_W'(1);
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk_50m) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_index    <= 4'd0;
      r_dur      <= 4'd0;
      r_paused   <= 1'b0;
      o_freq_div <= 16'd0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_index    <= w_index_nxt;
      r_dur      <= w_dur_nxt;
      r_paused   <= w_paused_nxt;
      o_freq_div <= w_freq_nxt;
      o_busy     <= (w_state_nxt != S_IDLE);
      o_done     <= w_done_nxt;
    end
  end

  // Next-state and next-output logic; priority STOP > mapped key > state flow.
  always_comb begin
    w_state_nxt  = r_state;
    w_index_nxt  = r_index;
    w_dur_nxt    = r_dur;
    w_paused_nxt = r_paused;
    w_freq_nxt   = o_freq_div;
    w_done_nxt   = 1'b0;
    w_restart    = 1'b0;

    if (i_stop) begin
      w_state_nxt  = S_IDLE;
      w_index_nxt  = 4'd0;
      w_paused_nxt = 1'b0;
      w_freq_nxt   = 16'd0;
    end else if (i_key_valid && w_key_hit) begin
      // Only an interrupted melody is remembered; a re-trigger keeps the flag.
      if ((r_state == S_LOAD) || (r_state == S_PLAY) || (r_state == S_GAP)) begin
        w_paused_nxt = 1'b1;
      end
      w_restart   = (r_state == S_MANUAL);
      w_state_nxt = S_MANUAL;
      w_freq_nxt  = note_div(w_key_idx);
    end else begin
      case (r_state)
        S_IDLE: begin
          w_freq_nxt = 16'd0;
          if (i_play) begin
            w_state_nxt = S_LOAD;
            w_index_nxt = 4'd0;
          end
        end
        S_LOAD: begin
          if (w_end) begin
            if (LOOP_EN) begin
              w_index_nxt = 4'd0;
            end else begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
              w_freq_nxt  = 16'd0;
            end
          end else begin
            w_state_nxt = S_PLAY;
            w_dur_nxt   = w_rom_dur;
            w_freq_nxt  = note_div(w_rom_note);
          end
        end
        S_PLAY: begin
          if (w_expire) begin
            w_state_nxt = S_GAP;
            w_freq_nxt  = 16'd0;
          end
        end
        S_GAP: begin
          if (w_expire) begin
            w_state_nxt = S_LOAD;
            w_index_nxt = r_index + 4'd1;
          end
        end
        S_MANUAL: begin
          if (w_expire) begin
            w_freq_nxt = 16'd0;
            if (r_paused) begin
              // Resume through GAP so the interrupted entry is skipped.
              w_paused_nxt = 1'b0;
              w_state_nxt  = S_GAP;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_freq_nxt  = 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beep_note_sequencer.sv
// Scoreboard bench for beep_note_sequencer. Stimulus pushes the expected
// per-cycle {freq, busy, done} trace; the monitor pops one entry per cycle.
module tb_beep_note_sequencer;

  typedef struct {
    logic [15:0] freq;
    logic        busy;
    logic        done;
    int          tid;
    int          idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   seq     = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;

  logic        play = 1'b0, stop = 1'b0, kv = 1'b0;
  logic [7:0]  kc = 8'h00;
  logic [15:0] m_freq;
  logic        m_busy, m_done;

  logic        l_play = 1'b0, l_stop = 1'b0, l_kv = 1'b0;
  logic [7:0]  l_kc = 8'h00;
  logic [15:0] l_freq;
  logic        l_busy, l_done;

  int song_f[8] = '{47774, 47774, 31888, 31888, 28409, 28409, 31888, 0};
  int song_d[8] = '{1, 1, 1, 1, 1, 1, 2, 1};

  beep_note_sequencer #(
    .TICK_DIV(10), .BEAT_MS(4), .GAP_MS(1), .MANUAL_MS(3), .SONG_LEN(8), .LOOP(0)
  ) dut (
    .i_clk_50m(clk), .i_rst_n(rst_n), .i_play(play), .i_stop(stop),
    .i_key_valid(kv), .i_key_code(kc),
    .o_freq_div(m_freq), .o_busy(m_busy), .o_done(m_done)
  );

  beep_note_sequencer #(
    .TICK_DIV(10), .BEAT_MS(4), .GAP_MS(1), .MANUAL_MS(3), .SONG_LEN(8), .LOOP(1)
  ) dut_loop (
    .i_clk_50m(clk), .i_rst_n(rst_n), .i_play(l_play), .i_stop(l_stop),
    .i_key_valid(l_kv), .i_key_code(l_kc),
    .o_freq_div(l_freq), .o_busy(l_busy), .o_done(l_done)
  );

  initial forever #5 clk = ~clk;

  // Monitor: one expected entry per cycle, sampled just after the rising edge.
  initial begin : monitor
    exp_t        e;
    logic [15:0] af;
    logic        ab, ad;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        af = sel ? l_freq : m_freq;
        ab = sel ? l_busy : m_busy;
        ad = sel ? l_done : m_done;
        n_tests++;
        if ((af !== e.freq) || (ab !== e.busy) || (ad !== e.done)) begin
          n_fail++;
          $display("FAIL t%0d[%0d] freq/busy/done got %0d/%0b/%0b exp %0d/%0b/%0b",
                   e.tid, e.idx, af, ab, ad, e.freq, e.busy, e.done);
        end
      end
    end
  end

  task automatic push(input int tid, input int f, input bit b, input bit d, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.freq = 16'(f);
      e.busy = b;
      e.done = d;
      e.tid  = tid;
      e.idx  = seq;
      seq++;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int tid);
    int budget;
    budget = 3000;
    while ((exp_q.size() > 0) && (budget > 0)) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL t%0d drain timeout, %0d entries left, exp 0", tid, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    seq = 0;
  endtask

  // Whole melody from the initial LOAD up to (and including) the end-of-song LOAD.
  task automatic push_song(input int tid);
    push(tid, 0, 1'b1, 1'b0, 1);
    for (int i = 0; i < 8; i++) begin
      push(tid, song_f[i], 1'b1, 1'b0, 40 * song_d[i]);
      push(tid, 0, 1'b1, 1'b0, 11);
    end
  endtask

  initial begin : stim
    int t;

    // Reset values on both instances.
    @(negedge clk);
    sel = 1'b0;
    push(0, 0, 1'b0, 1'b0, 3);
    wait_neg(3);
    sel = 1'b1;
    push(0, 0, 1'b0, 1'b0, 2);
    wait_neg(2);
    rst_n = 1'b1;
    drain(0);
    sel = 1'b0;

    // 1: full melody, DONE once after entry 7's gap, then idle.
    play = 1'b1;
    push_song(1);
    push(1, 0, 1'b0, 1'b1, 1);
    push(1, 0, 1'b0, 1'b0, 4);
    wait_neg(1);
    play = 1'b0;
    drain(1);

    // 2: LOOP=1 restarts at entry 0 without DONE.
    sel = 1'b1;
    l_play = 1'b1;
    push_song(2);
    push(2, 0, 1'b1, 1'b0, 1);
    push(2, 47774, 1'b1, 1'b0, 40);
    t = exp_q.size();
    push(2, 0, 1'b0, 1'b0, 3);
    wait_neg(1);
    l_play = 1'b0;
    wait_neg(t - 1);
    l_stop = 1'b1;
    wait_neg(1);
    l_stop = 1'b0;
    drain(2);
    sel = 1'b0;

    // 3: key 0x74 during entry 2 preempts, melody resumes at entry 3.
    play = 1'b1;
    push(3, 0, 1'b1, 1'b0, 1);
    push(3, 47774, 1'b1, 1'b0, 40);
    push(3, 0, 1'b1, 1'b0, 11);
    push(3, 47774, 1'b1, 1'b0, 40);
    push(3, 0, 1'b1, 1'b0, 11);
    push(3, 31888, 1'b1, 1'b0, 7);
    push(3, 28409, 1'b1, 1'b0, 30);
    push(3, 0, 1'b1, 1'b0, 11);
    push(3, 31888, 1'b1, 1'b0, 40);
    push(3, 0, 1'b0, 1'b0, 3);
    wait_neg(1);
    play = 1'b0;
    wait_neg(109);
    kv = 1'b1; kc = 8'h74;
    wait_neg(1);
    kv = 1'b0;
    wait_neg(80);
    stop = 1'b1;
    wait_neg(1);
    stop = 1'b0;
    drain(3);

    // 4: unmapped key ignored in IDLE, then 0x7D plays 30 cycles and returns to IDLE.
    kv = 1'b1; kc = 8'h55;
    push(4, 0, 1'b0, 1'b0, 3);
    push(4, 21276, 1'b1, 1'b0, 30);
    push(4, 0, 1'b0, 1'b0, 3);
    wait_neg(1);
    kv = 1'b0;
    wait_neg(2);
    kv = 1'b1; kc = 8'h7D;
    wait_neg(1);
    kv = 1'b0;
    drain(4);

    // 5: STOP + key + PLAY together mid-song -> IDLE; next PLAY starts at entry 0.
    play = 1'b1;
    push(5, 0, 1'b1, 1'b0, 1);
    push(5, 47774, 1'b1, 1'b0, 40);
    push(5, 0, 1'b1, 1'b0, 11);
    push(5, 47774, 1'b1, 1'b0, 40);
    push(5, 0, 1'b1, 1'b0, 11);
    push(5, 31888, 1'b1, 1'b0, 17);
    push(5, 0, 1'b0, 1'b0, 3);
    wait_neg(1);
    play = 1'b0;
    wait_neg(119);
    stop = 1'b1; kv = 1'b1; kc = 8'h69; play = 1'b1;
    wait_neg(1);
    stop = 1'b0; kv = 1'b0; play = 1'b0;
    drain(5);
    play = 1'b1;
    push(5, 0, 1'b1, 1'b0, 1);
    push(5, 47774, 1'b1, 1'b0, 40);
    push(5, 0, 1'b0, 1'b0, 3);
    wait_neg(1);
    play = 1'b0;
    wait_neg(40);
    stop = 1'b1;
    wait_neg(1);
    stop = 1'b0;
    drain(5);

    // 7: silence key 0x70 re-triggers MANUAL with FREQ_DIV=0 and a fresh 30 cycles.
    kv = 1'b1; kc = 8'h7D;
    push(7, 21276, 1'b1, 1'b0, 10);
    push(7, 0, 1'b1, 1'b0, 30);
    push(7, 0, 1'b0, 1'b0, 3);
    wait_neg(1);
    kv = 1'b0;
    wait_neg(9);
    kv = 1'b1; kc = 8'h70;
    wait_neg(1);
    kv = 1'b0;
    drain(7);

    // 6: reset during paused MANUAL -> reset values, no resume afterwards.
    play = 1'b1;
    push(6, 0, 1'b1, 1'b0, 1);
    push(6, 47774, 1'b1, 1'b0, 19);
    push(6, 31888, 1'b1, 1'b0, 5);
    push(6, 0, 1'b0, 1'b0, 50);
    wait_neg(1);
    play = 1'b0;
    wait_neg(19);
    kv = 1'b1; kc = 8'h73;
    wait_neg(1);
    kv = 1'b0;
    wait_neg(4);
    rst_n = 1'b0;
    wait_neg(1);
    rst_n = 1'b1;
    drain(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending, exp 0", exp_q.size());
    $fatal(1, "watchdog");
  end

endmodule
